// File: rtl/fractal_sync_mp_remote_cam.sv
// rtl/fractal_sync_mp_remote_cam.sv - multi-port barrier-pairing CAM with timeout eviction, flush and occupancy
module fractal_sync_mp_remote_cam #(
    parameter int LEVEL_WIDTH = 2,
    parameter int ID_WIDTH    = 2,
    parameter int N_PORTS     = 4,
    parameter int N_LINES     = 4,
    parameter int MAX_LEVEL   = 2**LEVEL_WIDTH-1,
    parameter int AGE_WIDTH   = 8,
    parameter int TIMEOUT     = 200
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    flush_i,
    input  logic [N_PORTS-1:0]                      req_i,
    input  logic [N_PORTS-1:0][LEVEL_WIDTH-1:0]     level_i,
    input  logic [N_PORTS-1:0][ID_WIDTH-1:0]        id_i,
    output logic [N_PORTS-1:0]                      rsp_valid_o,
    output logic [N_PORTS-1:0]                      present_o,
    output logic [N_PORTS-1:0]                      bypass_o,
    output logic [N_PORTS-1:0]                      ignore_o,
    output logic [N_PORTS-1:0]                      sig_err_o,
    output logic [N_PORTS-1:0]                      full_err_o,
    output logic                                    timeout_o,
    output logic [LEVEL_WIDTH+ID_WIDTH-1:0]         timeout_sig_o,
    output logic [$clog2(N_LINES+1)-1:0]            occupancy_o
);

    localparam int SIG_W = LEVEL_WIDTH + ID_WIDTH;
    localparam int OCC_W = $clog2(N_LINES+1);
    localparam logic [LEVEL_WIDTH-1:0] MAX_LVL     = LEVEL_WIDTH'(MAX_LEVEL);
    localparam logic [AGE_WIDTH-1:0]   TIMEOUT_AGE = AGE_WIDTH'(TIMEOUT);
    localparam logic [AGE_WIDTH-1:0]   AGE_SAT     = '1;

    logic [SIG_W-1:0]     req_sig [N_PORTS];
    logic [N_PORTS-1:0]   legal;
    logic [N_PORTS-1:0]   paired;
    logic [N_PORTS-1:0]   pair_bypass;
    logic [N_PORTS-1:0]   pair_ignore;
    logic [N_PORTS-1:0]   remaining;
    logic [N_PORTS-1:0]   hit;
    logic [N_PORTS-1:0]   full_err;

    logic [N_LINES-1:0]   line_valid_q;
    logic [SIG_W-1:0]     line_sig_q [N_LINES];
    logic [AGE_WIDTH-1:0] line_age_q [N_LINES];

    logic [N_LINES-1:0]   hit_line;
    logic [N_LINES-1:0]   taken;
    logic [SIG_W-1:0]     alloc_sig [N_LINES];
    logic [N_LINES-1:0]   evict_line;
    logic                 evict;
    logic [SIG_W-1:0]     evict_sig;
    logic [N_LINES-1:0]   valid_d;
    logic [OCC_W-1:0]     occ_d;

    // Same-cycle pairing: paired[i] doubles as the "partner already found" flag.
    always_comb begin
        paired      = '0;
        pair_bypass = '0;
        pair_ignore = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            req_sig[p] = {level_i[p], id_i[p]};
            legal[p]   = req_i[p] && (level_i[p] <= MAX_LVL);
        end
        for (int i = 0; i < N_PORTS; i++) begin
            if (legal[i] && !paired[i]) begin
                for (int j = i + 1; j < N_PORTS; j++) begin
                    if (!paired[i] && legal[j] && !paired[j] && req_sig[j] == req_sig[i]) begin
                        pair_bypass[i] = 1'b1;
                        pair_ignore[j] = 1'b1;
                        paired[i]      = 1'b1;
                        paired[j]      = 1'b1;
                    end
                end
            end
        end
        remaining = legal & ~paired & {N_PORTS{~flush_i}};
    end

    always_comb begin
        hit      = '0;
        hit_line = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (remaining[p]) begin
                for (int l = 0; l < N_LINES; l++) begin
                    if (!hit[p] && line_valid_q[l] && line_sig_q[l] == req_sig[p]) begin
                        hit[p]      = 1'b1;
                        hit_line[l] = 1'b1;
                    end
                end
            end
        end
    end

    // Only lines invalid at the start of the cycle are candidates; full_err[p] is cleared once a line is taken.
    always_comb begin
        taken    = '0;
        full_err = '0;
        for (int l = 0; l < N_LINES; l++) begin
            alloc_sig[l] = '0;
        end
        for (int p = 0; p < N_PORTS; p++) begin
            if (remaining[p] && !hit[p]) begin
                full_err[p] = 1'b1;
                for (int l = 0; l < N_LINES; l++) begin
                    if (full_err[p] && !line_valid_q[l] && !taken[l]) begin
                        taken[l]     = 1'b1;
                        alloc_sig[l] = req_sig[p];
                        full_err[p]  = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        evict      = 1'b0;
        evict_line = '0;
        evict_sig  = '0;
        if (TIMEOUT > 0 && !flush_i) begin
            for (int l = 0; l < N_LINES; l++) begin
                if (!evict && line_valid_q[l] && !hit_line[l] && line_age_q[l] >= TIMEOUT_AGE) begin
                    evict         = 1'b1;
                    evict_line[l] = 1'b1;
                    evict_sig     = line_sig_q[l];
                end
            end
        end
    end

    always_comb begin
        valid_d = flush_i ? '0 : ((line_valid_q & ~hit_line & ~evict_line) | taken);
        occ_d   = '0;
        for (int l = 0; l < N_LINES; l++) begin
            occ_d = occ_d + OCC_W'(valid_d[l]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_valid_q  <= '0;
            for (int l = 0; l < N_LINES; l++) begin
                line_sig_q[l] <= '0;
                line_age_q[l] <= '0;
            end
            rsp_valid_o   <= '0;
            present_o     <= '0;
            bypass_o      <= '0;
            ignore_o      <= '0;
            sig_err_o     <= '0;
            full_err_o    <= '0;
            timeout_o     <= 1'b0;
            timeout_sig_o <= '0;
            occupancy_o   <= '0;
        end else begin
            line_valid_q <= valid_d;
            for (int l = 0; l < N_LINES; l++) begin
                if (taken[l] && !flush_i) begin
                    line_sig_q[l] <= alloc_sig[l];
                    line_age_q[l] <= '0;
                end else if (valid_d[l]) begin
                    line_age_q[l] <= (line_age_q[l] == AGE_SAT) ? AGE_SAT : line_age_q[l] + AGE_WIDTH'(1);
                end else begin
                    line_age_q[l] <= '0;
                end
            end
            rsp_valid_o   <= req_i;
            present_o     <= hit;
            bypass_o      <= pair_bypass;
            ignore_o      <= pair_ignore;
            sig_err_o     <= req_i & ~legal;
            full_err_o    <= full_err;
            timeout_o     <= evict;
            timeout_sig_o <= evict_sig;
            occupancy_o   <= occ_d;
        end
    end

endmodule

// File: tb/tb_fractal_sync_mp_remote_cam.sv
// tb/tb_fractal_sync_mp_remote_cam.sv - directed self-checking bench for fractal_sync_mp_remote_cam
module tb_fractal_sync_mp_remote_cam;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [3:0]      req;
    logic [3:0][1:0] level;
    logic [3:0][1:0] id;
    logic [3:0]      rsp_valid, present, bypass, ignore, sig_err, full_err;
    logic            timeout;
    logic [3:0]      timeout_sig;
    logic [2:0]      occ;
    logic [23:0]     flags;

    int checks = 0;
    int passed = 0;

    // Nibbles: rsp_valid, present, bypass, ignore, sig_err, full_err
    assign flags = {rsp_valid, present, bypass, ignore, sig_err, full_err};

    fractal_sync_mp_remote_cam #(
        .LEVEL_WIDTH(2), .ID_WIDTH(2), .N_PORTS(4), .N_LINES(4),
        .MAX_LEVEL(2), .AGE_WIDTH(8), .TIMEOUT(10)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_i(req), .level_i(level), .id_i(id),
        .rsp_valid_o(rsp_valid), .present_o(present), .bypass_o(bypass),
        .ignore_o(ignore), .sig_err_o(sig_err), .full_err_o(full_err),
        .timeout_o(timeout), .timeout_sig_o(timeout_sig), .occupancy_o(occ)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req   = '0;
        level = '0;
        id    = '0;
        flush = 1'b0;
    endtask

    task automatic put(input int p, input int lv, input int i);
        req[p]   = 1'b1;
        level[p] = lv[1:0];
        id[p]    = i[1:0];
    endtask

    task automatic clean();
        idle();
        flush = 1'b1;
        step();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        put(0, 1, 1);
        step();
        checks++; if (flags !== 24'h0) $display("FAIL reset_flags got %h want %h", flags, 24'h0); else passed++;
        checks++; if (occ !== 3'd0) $display("FAIL reset_occ got %0d want 0", occ); else passed++;
        checks++; if ({timeout, timeout_sig} !== 5'h0) $display("FAIL reset_timeout got %h want 0", {timeout, timeout_sig}); else passed++;
        rst = 1'b0;
        idle();
        step();
        checks++; if (flags !== 24'h0) $display("FAIL post_reset_flags got %h want %h", flags, 24'h0); else passed++;
    endtask

    task automatic test_store_match();
        clean();
        put(0, 1, 2);
        step();
        checks++; if (flags !== 24'h100000) $display("FAIL store_flags got %h want %h", flags, 24'h100000); else passed++;
        checks++; if (occ !== 3'd1) $display("FAIL store_occ got %0d want 1", occ); else passed++;
        idle();
        repeat (4) step();
        checks++; if (flags !== 24'h0) $display("FAIL idle_flags got %h want %h", flags, 24'h0); else passed++;
        put(3, 1, 2);
        step();
        checks++; if (flags !== 24'h880000) $display("FAIL match_flags got %h want %h", flags, 24'h880000); else passed++;
        checks++; if (occ !== 3'd0) $display("FAIL match_occ got %0d want 0", occ); else passed++;
    endtask

    task automatic test_back_to_back();
        clean();
        put(0, 0, 2);
        step();
        checks++; if (flags !== 24'h100000) $display("FAIL b2b_store got %h want %h", flags, 24'h100000); else passed++;
        idle();
        put(1, 0, 2);
        step();
        checks++; if (flags !== 24'h220000) $display("FAIL b2b_match got %h want %h", flags, 24'h220000); else passed++;
        checks++; if (occ !== 3'd0) $display("FAIL b2b_occ got %0d want 0", occ); else passed++;
    endtask

    task automatic test_pairing();
        clean();
        put(0, 0, 1); put(1, 0, 1); put(2, 0, 1);
        step();
        checks++; if (flags !== 24'h701200) $display("FAIL pair3_flags got %h want %h", flags, 24'h701200); else passed++;
        checks++; if (occ !== 3'd1) $display("FAIL pair3_occ got %0d want 1", occ); else passed++;
        idle();
        put(0, 2, 0); put(2, 2, 0);
        step();
        checks++; if (flags !== 24'h501400) $display("FAIL pair02_flags got %h want %h", flags, 24'h501400); else passed++;
        checks++; if (occ !== 3'd1) $display("FAIL pair02_occ got %0d want 1", occ); else passed++;
        idle();
        put(1, 0, 1);
        step();
        checks++; if (flags !== 24'h220000) $display("FAIL pair_left_match got %h want %h", flags, 24'h220000); else passed++;
        checks++; if (occ !== 3'd0) $display("FAIL pair_left_occ got %0d want 0", occ); else passed++;
    endtask

    task automatic test_full();
        clean();
        put(0, 0, 0); put(1, 0, 1); put(2, 0, 2); put(3, 0, 3);
        step();
        checks++; if (flags !== 24'hF00000) $display("FAIL fill_flags got %h want %h", flags, 24'hF00000); else passed++;
        checks++; if (occ !== 3'd4) $display("FAIL fill_occ got %0d want 4", occ); else passed++;
        idle();
        put(0, 1, 0);
        step();
        checks++; if (flags !== 24'h100001) $display("FAIL full_flags got %h want %h", flags, 24'h100001); else passed++;
        checks++; if (occ !== 3'd4) $display("FAIL full_occ got %0d want 4", occ); else passed++;
        idle();
        put(0, 0, 0); put(1, 1, 1);
        step();
        checks++; if (flags !== 24'h310002) $display("FAIL hit_full_flags got %h want %h", flags, 24'h310002); else passed++;
        checks++; if (occ !== 3'd3) $display("FAIL hit_full_occ got %0d want 3", occ); else passed++;
        idle();
        put(1, 1, 1);
        step();
        checks++; if (flags !== 24'h200000) $display("FAIL retry_flags got %h want %h", flags, 24'h200000); else passed++;
        checks++; if (occ !== 3'd4) $display("FAIL retry_occ got %0d want 4", occ); else passed++;
        clean();
        checks++; if (occ !== 3'd0) $display("FAIL full_flush_occ got %0d want 0", occ); else passed++;
    endtask

    task automatic test_timeout();
        clean();
        put(0, 2, 3);
        step();
        idle();
        repeat (10) step();
        checks++; if (timeout !== 1'b0 || occ !== 3'd1) $display("FAIL pre_timeout got to=%b occ=%0d want to=0 occ=1", timeout, occ); else passed++;
        step();
        checks++; if (timeout !== 1'b1) $display("FAIL timeout_pulse got %b want 1", timeout); else passed++;
        checks++; if (timeout_sig !== 4'hB) $display("FAIL timeout_sig got %h want b", timeout_sig); else passed++;
        checks++; if (occ !== 3'd0) $display("FAIL timeout_occ got %0d want 0", occ); else passed++;
        step();
        checks++; if (timeout !== 1'b0) $display("FAIL timeout_one_cycle got %b want 0", timeout); else passed++;
        clean();
        put(0, 2, 3);
        step();
        idle();
        repeat (10) step();
        put(0, 2, 3);
        step();
        checks++; if (flags !== 24'h110000) $display("FAIL expiry_hit_flags got %h want %h", flags, 24'h110000); else passed++;
        checks++; if (timeout !== 1'b0 || occ !== 3'd0) $display("FAIL expiry_hit_to got to=%b occ=%0d want to=0 occ=0", timeout, occ); else passed++;
        idle();
        step();
        checks++; if (timeout !== 1'b0) $display("FAIL expiry_hit_late_to got %b want 0", timeout); else passed++;
    endtask

    task automatic test_sig_err();
        clean();
        put(1, 3, 0);
        step();
        checks++; if (flags !== 24'h200020) $display("FAIL sigerr_flags got %h want %h", flags, 24'h200020); else passed++;
        checks++; if (occ !== 3'd0) $display("FAIL sigerr_occ got %0d want 0", occ); else passed++;
        idle();
        put(0, 3, 1); put(2, 3, 1);
        step();
        checks++; if (flags !== 24'h500050) $display("FAIL sigerr_nopair got %h want %h", flags, 24'h500050); else passed++;
        checks++; if (occ !== 3'd0) $display("FAIL sigerr_nopair_occ got %0d want 0", occ); else passed++;
    endtask

    task automatic test_flush();
        clean();
        put(0, 1, 0); put(1, 1, 1); put(2, 1, 2);
        step();
        checks++; if (occ !== 3'd3) $display("FAIL flush_fill_occ got %0d want 3", occ); else passed++;
        idle();
        flush = 1'b1;
        put(0, 1, 0); put(1, 2, 2); put(3, 2, 2);
        step();
        checks++; if (flags !== 24'hB02800) $display("FAIL flush_flags got %h want %h", flags, 24'hB02800); else passed++;
        checks++; if (occ !== 3'd0) $display("FAIL flush_occ got %0d want 0", occ); else passed++;
        idle();
        put(0, 1, 1);
        step();
        checks++; if (flags !== 24'h100000) $display("FAIL post_flush_store got %h want %h", flags, 24'h100000); else passed++;
    endtask

    task automatic test_reset_mid();
        idle();
        rst = 1'b1;
        put(0, 1, 1);
        step();
        checks++; if (flags !== 24'h0 || occ !== 3'd0 || timeout !== 1'b0) $display("FAIL mid_reset got flags=%h occ=%0d to=%b want 0", flags, occ, timeout); else passed++;
        rst = 1'b0;
        idle();
        put(0, 1, 1);
        step();
        checks++; if (flags !== 24'h100000) $display("FAIL mid_reset_store got %h want %h", flags, 24'h100000); else passed++;
        checks++; if (occ !== 3'd1) $display("FAIL mid_reset_occ got %0d want 1", occ); else passed++;
        clean();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_store_match();
        test_back_to_back();
        test_pairing();
        test_full();
        test_timeout();
        test_sig_err();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
